upp_frame_reader: RTL and testbench
===================================

Name: upp_frame_reader

Overview:
- Read-side sequencer directly downstream of the dual-channel (A/B) BLVDS receive FIFO switch. Runs in the 70 MHz read domain.
- Waits until the selected FIFO channel holds one complete frame, then reads exactly FRAME_LEN words and streams them to the uPP transmit port with start/enable framing.
- Flips the read channel select after every completed frame (ping-pong) and reports frame count and underrun.

Parameters:
- FRAME_LEN, 256, words per frame; legal range 2..511 (FIFO usedw is 9 bits).
- DW, 16, data width.
- UW, 9, width of the FIFO read-used-words input.

Ports:
- iC2_70MHZ  in  1  clock, also the FIFO read clock.
- iRST  in  1  synchronous reset, active-high.
- iEN  in  1  enable. Sampled only in IDLE.
- iRD_EMPTY  in  1  empty flag of the selected FIFO channel.
- iRDUSEDW  in  UW  words available in the selected channel.
- iFIFO_OUT  in  DW  FIFO q. Non-showahead: valid the cycle after rdreq.
- iUPP_WAIT  in  1  uPP back-pressure, active-high.
- oSEL_CH_RD  out  1  read channel select (1 = channel A, 0 = channel B).
- oRD_REQ  out  1  FIFO read request. Combinational from state/count/flags.
- oUPP_DATA  out  DW  registered output word.
- oUPP_ENABLE  out  1  registered. High for exactly one cycle per word transferred.
- oUPP_START  out  1  registered. High together with oUPP_ENABLE on the first word of a frame only.
- oFRAME_DONE  out  1  one-cycle pulse with the last word's oUPP_ENABLE.
- oFRAME_CNT  out  16  completed frames. Wraps 0xFFFF -> 0.
- oUNDERRUN  out  1  sticky error flag. Cleared only by iRST.
- oBUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (iRST=1 at an edge): state=IDLE, oSEL_CH_RD=1, oRD_REQ=0, oUPP_DATA=0, oUPP_ENABLE=0, oUPP_START=0, oFRAME_DONE=0, oFRAME_CNT=0, oUNDERRUN=0, read count=0, pipeline valid bits cleared.
- Reset mid-frame aborts the frame. Words already requested are discarded, the select returns to A, and the count does not increment.
- States and transitions:
  - IDLE: if iEN && iRDUSEDW >= FRAME_LEN, go to READ and load rd_cnt=FRAME_LEN.
  - READ: oRD_REQ = !iUPP_WAIT && !iRD_EMPTY. Each asserted oRD_REQ decrements rd_cnt. When oRD_REQ is asserted with rd_cnt==1, go to DRAIN.
  - DRAIN: wait until both pipeline stages are empty, then go to SWITCH.
  - SWITCH: invert oSEL_CH_RD, increment oFRAME_CNT, go to SETTLE.
  - SETTLE: one idle cycle so the muxed iRDUSEDW/iRD_EMPTY reflect the new channel, then go to IDLE.
- Pipeline: oRD_REQ at cycle t makes v1 high at t+1 (iFIFO_OUT valid). At the edge ending t+1, iFIFO_OUT is captured into oUPP_DATA and oUPP_ENABLE is set, so it is visible at t+2. Latency rdreq -> oUPP_ENABLE is 2 cycles.
- Back-to-back rdreq gives a continuous enable stream, one word per clock.
- iUPP_WAIT:
  - Stops new requests in the same cycle.
  - Up to 1 already-requested word is still delivered (v1 at the WAIT edge). The uPP side is specified to absorb it.
  - oUPP_ENABLE is never high two cycles after WAIT rose unless WAIT has fallen again.
- oUPP_START marks the word produced by the first rdreq of the frame, tracked by a first-word flag cleared on the first request. oFRAME_DONE marks the word produced by the final request.
- Underrun: iRD_EMPTY=1 in READ with rd_cnt>0 sets oUNDERRUN (sticky). Requests pause and resume when empty falls, and the frame still completes with FRAME_LEN words. Because IDLE gates the start on usedw, underrun indicates an upstream fault.
- iEN low during a frame does not abort it. The current frame and channel switch complete, then the block stays in IDLE.
- No rdreq is ever issued when iRD_EMPTY=1, in IDLE, or in DRAIN/SWITCH/SETTLE.
- Exactly FRAME_LEN oUPP_ENABLE pulses are produced per frame.
- Start threshold boundary: iRDUSEDW == FRAME_LEN starts a frame; FRAME_LEN-1 does not.

Test Plan:
- Reset, then FRAME_LEN=8, channel A preloaded with 0x0001..0x0008, iEN=1, WAIT=0 -> 8 consecutive oUPP_ENABLE cycles, first at 3 cycles after IDLE->READ; data 0x0001..0x0008; START on 0x0001, DONE on 0x0008; then oSEL_CH_RD=0 and oFRAME_CNT=1.
- A and B each hold one 8-word frame (A: 0xA000.., B: 0xB000..) -> A frame, switch, B frame, switch; oSEL_CH_RD sequence 1,0,1; oFRAME_CNT=2; no rdreq during SWITCH/SETTLE.
- iRDUSEDW=7 with FRAME_LEN=8 -> stays in IDLE, oRD_REQ=0; raise usedw to 8 -> frame starts the next cycle.
- iUPP_WAIT high for 4 cycles at word 3 -> no rdreq while high; at most 1 enable after the WAIT rise; all 8 words delivered in order, no duplicates or drops.
- Force iRD_EMPTY=1 for 3 cycles at word 5 -> oUNDERRUN=1 and stays 1; rdreq held low; frame completes with 8 words.
- iRST asserted at word 4 -> all outputs at reset values next cycle; oSEL_CH_RD=1; oFRAME_CNT=0; a fresh frame then runs normally.

Source files
------------

// File: rtl/upp_frame_reader_if.sv
// Signal bundle between the frame reader, the muxed A/B receive FIFO read port and the uPP transmit port.
interface upp_frame_reader_if #(
   parameter int DW = 16,
   parameter int UW = 9
);
   logic          iEN;
   logic          iRD_EMPTY;
   logic [UW-1:0] iRDUSEDW;
   logic [DW-1:0] iFIFO_OUT;
   logic          iUPP_WAIT;
   logic          oSEL_CH_RD;
   logic          oRD_REQ;
   logic [DW-1:0] oUPP_DATA;
   logic          oUPP_ENABLE;
   logic          oUPP_START;
   logic          oFRAME_DONE;
   logic [15:0]   oFRAME_CNT;
   logic          oUNDERRUN;
   logic          oBUSY;

   modport master (
      input  iEN, iRD_EMPTY, iRDUSEDW, iFIFO_OUT, iUPP_WAIT,
      output oSEL_CH_RD, oRD_REQ, oUPP_DATA, oUPP_ENABLE, oUPP_START,
             oFRAME_DONE, oFRAME_CNT, oUNDERRUN, oBUSY
   );

   modport slave (
      output iEN, iRD_EMPTY, iRDUSEDW, iFIFO_OUT, iUPP_WAIT,
      input  oSEL_CH_RD, oRD_REQ, oUPP_DATA, oUPP_ENABLE, oUPP_START,
             oFRAME_DONE, oFRAME_CNT, oUNDERRUN, oBUSY
   );
endinterface

// File: rtl/upp_frame_reader.sv
// Ping-pong read sequencer: pulls one whole frame from the selected A/B receive FIFO channel,
// streams it to the uPP port with start/enable framing, then flips the channel select.
module upp_frame_reader #(
   parameter int FRAME_LEN = 256,
   parameter int DW        = 16,
   parameter int UW        = 9
) (
   input  logic               iC2_70MHZ,
   input  logic               iRST,
   upp_frame_reader_if.master upp
);
   // state  | meaning
   // IDLE   | waiting for enable and a complete frame in the selected channel
   // READ   | issuing read requests, rdCnt words still to request
   // DRAIN  | every word requested, waiting for the two read stages to empty
   // SWITCH | flip the channel select and count the frame
   // SETTLE | one cycle for the muxed usedw/empty to follow the new select
   typedef enum logic [2:0] {IDLE, READ, DRAIN, SWITCH, SETTLE} state_t;

   localparam logic [UW-1:0] FRAME_LEN_W = UW'(FRAME_LEN);
   localparam logic [UW-1:0] ONE_W       = UW'(1);

   state_t        state;
   logic [UW-1:0] rdCnt;
   logic          firstWord;
   logic          v1;
   logic          start1;
   logic          last1;
   logic          rdReq;
   logic          selCh;
   logic [DW-1:0] uppData;
   logic          uppEnable;
   logic          uppStart;
   logic          frameDone;
   logic [15:0]   frameCnt;
   logic          underrun;

   // Gated by iRST so a reset cycle never pops a word out of the FIFO.
   assign rdReq = (state == READ) && !iRST && !upp.iUPP_WAIT && !upp.iRD_EMPTY;

   assign upp.oRD_REQ     = rdReq;
   assign upp.oBUSY       = (state != IDLE);
   assign upp.oSEL_CH_RD  = selCh;
   assign upp.oUPP_DATA   = uppData;
   assign upp.oUPP_ENABLE = uppEnable;
   assign upp.oUPP_START  = uppStart;
   assign upp.oFRAME_DONE = frameDone;
   assign upp.oFRAME_CNT  = frameCnt;
   assign upp.oUNDERRUN   = underrun;

   always_ff @(posedge iC2_70MHZ) begin
      if (iRST) begin
         state     <= IDLE;
         rdCnt     <= '0;
         firstWord <= 1'b0;
         v1        <= 1'b0;
         start1    <= 1'b0;
         last1     <= 1'b0;
         selCh     <= 1'b1;
         uppData   <= '0;
         uppEnable <= 1'b0;
         uppStart  <= 1'b0;
         frameDone <= 1'b0;
         frameCnt  <= '0;
         underrun  <= 1'b0;
      end else begin
         // Stage 1 marks the cycle iFIFO_OUT is valid; stage 2 is the registered uPP word.
         v1        <= rdReq;
         start1    <= rdReq && firstWord;
         last1     <= rdReq && (rdCnt == ONE_W);
         uppEnable <= v1;
         uppStart  <= v1 && start1;
         frameDone <= v1 && last1;
         if (v1) begin
            uppData <= upp.iFIFO_OUT;
         end

         case (state)
            IDLE: begin
               if (upp.iEN && (upp.iRDUSEDW >= FRAME_LEN_W)) begin
                  state     <= READ;
                  rdCnt     <= FRAME_LEN_W;
                  firstWord <= 1'b1;
               end
            end
            READ: begin
               if (upp.iRD_EMPTY) begin
                  underrun <= 1'b1;
               end
               if (rdReq) begin
                  firstWord <= 1'b0;
                  rdCnt     <= rdCnt - ONE_W;
                  if (rdCnt == ONE_W) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!v1 && !uppEnable) begin
                  state <= SWITCH;
               end
            end
            SWITCH: begin
               selCh    <= ~selCh;
               frameCnt <= frameCnt + 16'd1;
               state    <= SETTLE;
            end
            SETTLE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_upp_frame_reader.sv
// Bench for upp_frame_reader: emulates the A/B FIFO pair and checks every cycle against a
// frame-level model (latency-2 word stream, fixed switch/settle timing after the last request).
module tb_upp_frame_reader;
   localparam int LEN = 8;
   localparam int DW  = 16;
   localparam int UW  = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #7 clk = ~clk;

   upp_frame_reader_if #(.DW(DW), .UW(UW)) upp ();

   upp_frame_reader #(.FRAME_LEN(LEN), .DW(DW), .UW(UW)) dut (
      .iC2_70MHZ(clk),
      .iRST     (rst),
      .upp      (upp)
   );

   typedef struct {
      int          due;
      logic [15:0] d;
      bit          s;
      bit          e;
   } word_t;

   logic [15:0] chA[$];
   logic [15:0] chB[$];

   // model of the expected behaviour
   int    cyc = 0;
   int    remaining = 0;
   int    readStart = 0;
   int    idleFrom = 0;
   int    decisionCyc = 0;
   bit    expSel = 1'b1;
   bit    expUnder = 1'b0;
   int    expCnt = 0;
   word_t pipeQ[$];
   int    doneQ[$];

   bit enDrv = 1'b0;
   bit waitDrv = 1'b0;
   bit forceEmpty = 1'b0;
   bit rstDrv = 1'b0;

   int enCnt = 0, startCnt = 0, doneCnt = 0, reqCnt = 0, firstEnCyc = -1;
   logic [15:0] firstData = '0, lastData = '0;

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic failNow(input string name);
      checks++;
      $display("FAIL %s: cycle budget exhausted at cycle %0d", name, cyc);
   endtask

   function automatic int chSize(input bit sel);
      return sel ? chA.size() : chB.size();
   endfunction

   function automatic logic [15:0] peek(input bit sel);
      if (sel) return (chA.size() > 0) ? chA[0] : 16'hDEAD;
      return (chB.size() > 0) ? chB[0] : 16'hDEAD;
   endfunction

   task automatic modelReset();
      remaining = 0;
      idleFrom  = cyc + 1;
      pipeQ.delete();
      doneQ.delete();
      expCnt   = 0;
      expSel   = 1'b1;
      expUnder = 1'b0;
   endtask

   task automatic mark();
      enCnt = 0; startCnt = 0; doneCnt = 0; reqCnt = 0; firstEnCyc = -1;
      firstData = '0; lastData = '0;
   endtask

   task automatic pushFrame(input bit toA, input logic [15:0] base, input bit randomData);
      logic [15:0] w;
      for (int i = 0; i < LEN; i++) begin
         w = randomData ? 16'($urandom) : base + 16'(i);
         if (toA) chA.push_back(w);
         else chB.push_back(w);
      end
   endtask

   task automatic step();
      bit    selNow, reqNow, emptyNow, expBusy, inRead, expReq, expEn;
      int    usedNow;
      word_t w;
      @(negedge clk);
      while (doneQ.size() > 0 && doneQ[0] == cyc) begin
         void'(doneQ.pop_front());
         expCnt = (expCnt + 1) & 32'hFFFF;
         expSel = ~expSel;
      end
      expEn = (pipeQ.size() > 0 && pipeQ[0].due == cyc);
      check("upp_enable", upp.oUPP_ENABLE, expEn);
      if (expEn) begin
         w = pipeQ.pop_front();
         check("upp_data", upp.oUPP_DATA, w.d);
         check("upp_start", upp.oUPP_START, w.s);
         check("frame_done", upp.oFRAME_DONE, w.e);
      end else begin
         check("start_done_idle", {upp.oUPP_START, upp.oFRAME_DONE}, 0);
      end
      check("frame_cnt", upp.oFRAME_CNT, expCnt);
      check("sel_ch_rd", upp.oSEL_CH_RD, expSel);
      check("underrun", upp.oUNDERRUN, expUnder);
      if (upp.oUPP_ENABLE === 1'b1) begin
         enCnt++;
         if (enCnt == 1) begin
            firstData  = upp.oUPP_DATA;
            firstEnCyc = cyc;
         end
         lastData = upp.oUPP_DATA;
         if (upp.oUPP_START === 1'b1) startCnt++;
         if (upp.oFRAME_DONE === 1'b1) doneCnt++;
      end

      rst = rstDrv;
      upp.iEN = enDrv;
      upp.iUPP_WAIT = waitDrv;
      selNow = upp.oSEL_CH_RD;
      usedNow = chSize(selNow);
      if (usedNow > 511) usedNow = 511;
      upp.iRDUSEDW = UW'(usedNow);
      emptyNow = forceEmpty || (chSize(selNow) == 0);
      upp.iRD_EMPTY = emptyNow;
      #1;
      expBusy = !(remaining == 0 && cyc >= idleFrom);
      check("busy", upp.oBUSY, expBusy);
      inRead = (remaining > 0) && (cyc >= readStart);
      expReq = !rstDrv && inRead && !waitDrv && !emptyNow;
      reqNow = upp.oRD_REQ;
      check("rd_req", reqNow, expReq);
      if (reqNow) reqCnt++;
      if (rstDrv) begin
         modelReset();
      end else begin
         if (inRead && emptyNow) expUnder = 1'b1;
         if (expReq) begin
            w.due = cyc + 2;
            w.d   = peek(expSel);
            w.s   = (remaining == LEN);
            w.e   = (remaining == 1);
            pipeQ.push_back(w);
            remaining--;
            if (remaining == 0) begin
               doneQ.push_back(cyc + 5);
               idleFrom = cyc + 6;
            end
         end else if (!expBusy && enDrv && usedNow >= LEN) begin
            remaining   = LEN;
            readStart   = cyc + 1;
            decisionCyc = cyc;
         end
      end

      @(posedge clk);
      #1;
      if (reqNow) begin
         if (selNow && chA.size() > 0) upp.iFIFO_OUT = chA.pop_front();
         else if (!selNow && chB.size() > 0) upp.iFIFO_OUT = chB.pop_front();
      end
      cyc++;
   endtask

   function automatic bit modelQuiet();
      return (remaining == 0) && (cyc >= idleFrom) && (pipeQ.size() == 0) &&
             (doneQ.size() == 0) && !(enDrv && chSize(expSel) >= LEN);
   endfunction

   task automatic runUntilIdle(input string name, input int maxc);
      int n = 0;
      while (!modelQuiet() && n < maxc) begin
         step();
         n++;
      end
      if (!modelQuiet()) failNow(name);
      repeat (2) step();
   endtask

   task automatic runUntilReqs(input string name, input int target, input int maxc);
      int n = 0;
      while (reqCnt < target && n < maxc) begin
         step();
         n++;
      end
      if (reqCnt < target) failNow(name);
   endtask

   initial begin
      int e0, r0;
      upp.iEN = 1'b0;
      upp.iRD_EMPTY = 1'b1;
      upp.iRDUSEDW = '0;
      upp.iFIFO_OUT = '0;
      upp.iUPP_WAIT = 1'b0;
      repeat (2) @(posedge clk);

      // basic frame from channel A
      mark();
      step();
      check("rst_frame_cnt", upp.oFRAME_CNT, 0);
      check("rst_sel", upp.oSEL_CH_RD, 1);
      check("rst_busy", upp.oBUSY, 0);
      pushFrame(1'b1, 16'h0001, 1'b0);
      enDrv = 1'b1;
      runUntilIdle("t1_timeout", 100);
      check("t1_words", enCnt, 8);
      check("t1_first_data", firstData, 16'h0001);
      check("t1_last_data", lastData, 16'h0008);
      check("t1_start_cnt", startCnt, 1);
      check("t1_done_cnt", doneCnt, 1);
      check("t1_latency", firstEnCyc - decisionCyc, 3);
      check("t1_sel", upp.oSEL_CH_RD, 0);
      check("t1_cnt", upp.oFRAME_CNT, 1);

      // A then B back to back
      rstDrv = 1'b1;
      step();
      rstDrv = 1'b0;
      mark();
      pushFrame(1'b1, 16'hA000, 1'b0);
      pushFrame(1'b0, 16'hB000, 1'b0);
      runUntilIdle("t2_timeout", 200);
      check("t2_words", enCnt, 16);
      check("t2_first_data", firstData, 16'hA000);
      check("t2_last_data", lastData, 16'hB007);
      check("t2_cnt", upp.oFRAME_CNT, 2);
      check("t2_sel", upp.oSEL_CH_RD, 1);

      // start threshold: 7 words is not enough, 8 is
      mark();
      for (int i = 0; i < LEN - 1; i++) chA.push_back(16'h3000 + 16'(i));
      repeat (5) step();
      check("t3_no_req", reqCnt, 0);
      check("t3_idle", upp.oBUSY, 0);
      chA.push_back(16'h3007);
      runUntilIdle("t3_timeout", 100);
      check("t3_words", enCnt, 8);
      check("t3_cnt", upp.oFRAME_CNT, 3);

      // back-pressure at word 3 (channel B)
      mark();
      pushFrame(1'b0, 16'h4000, 1'b0);
      runUntilReqs("t4_reqs", 3, 50);
      waitDrv = 1'b1;
      r0 = reqCnt;
      step();
      e0 = enCnt;
      repeat (3) step();
      check("t4_no_req_in_wait", reqCnt, r0);
      waitDrv = 1'b0;
      step();
      check("t4_wait_absorb", (enCnt - e0) <= 1, 1);
      runUntilIdle("t4_timeout", 100);
      check("t4_words", enCnt, 8);
      check("t4_last_data", lastData, 16'h4007);

      // underrun at word 5 (channel A)
      mark();
      pushFrame(1'b1, 16'h5000, 1'b0);
      runUntilReqs("t5_reqs", 4, 50);
      forceEmpty = 1'b1;
      repeat (3) step();
      forceEmpty = 1'b0;
      runUntilIdle("t5_timeout", 100);
      check("t5_underrun", upp.oUNDERRUN, 1);
      check("t5_words", enCnt, 8);

      // reset mid-frame at word 4 (channel B)
      mark();
      pushFrame(1'b0, 16'h6000, 1'b0);
      runUntilReqs("t6_reqs", 3, 50);
      rstDrv = 1'b1;
      step();
      rstDrv = 1'b0;
      step();
      check("t6_cnt", upp.oFRAME_CNT, 0);
      check("t6_sel", upp.oSEL_CH_RD, 1);
      check("t6_underrun", upp.oUNDERRUN, 0);
      check("t6_busy", upp.oBUSY, 0);
      chA.delete();
      chB.delete();
      mark();
      pushFrame(1'b1, 16'h0101, 1'b0);
      runUntilIdle("t6_timeout", 100);
      check("t6_words", enCnt, 8);
      check("t6_first_data", firstData, 16'h0101);
      check("t6_cnt_after", upp.oFRAME_CNT, 1);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               if (chA.size() <= 400) pushFrame(1'b1, 16'h0, 1'b1);
            end else begin
               if (chB.size() <= 400) pushFrame(1'b0, 16'h0, 1'b1);
            end
         end
         waitDrv    = ($urandom_range(0, 9) < 2);
         forceEmpty = ($urandom_range(0, 49) == 0);
         enDrv      = ($urandom_range(0, 19) != 0);
         rstDrv     = ($urandom_range(0, 999) == 0);
         step();
      end
      waitDrv = 1'b0;
      forceEmpty = 1'b0;
      rstDrv = 1'b0;
      enDrv = 1'b0;
      runUntilIdle("rand_timeout", 200);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
